// File: rtl/shift_arbiter.sv
// Two-port arbiter in front of a shared 32-bit barrel shifter.
// The result is held in a single registered slot with valid/ready backpressure.
module shift_arbiter #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_d,
  input  logic [4:0]  req0_sa,
  input  logic        req0_right,
  input  logic        req0_arith,
  input  logic [3:0]  req0_tag,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_d,
  input  logic [4:0]  req1_sa,
  input  logic        req1_right,
  input  logic        req1_arith,
  input  logic [3:0]  req1_tag,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_sh,
  output logic        res_src,
  output logic [3:0]  res_tag,
  output logic        busy,
  output logic [15:0] done_cnt
);

  typedef enum logic {
    GRANT_P0 = 1'b0,
    GRANT_P1 = 1'b1
  } grant_e;

  grant_e      last_grant_q, last_grant_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_sh_q, res_sh_d;
  logic        res_src_q, res_src_d;
  logic [3:0]  res_tag_q, res_tag_d;
  logic [15:0] done_cnt_q, done_cnt_d;

  logic        slot_free;
  logic        gnt0, gnt1;
  logic        accept;
  logic [31:0] op_d;
  logic [4:0]  op_sa;
  logic        op_right;
  logic        op_arith;
  logic [3:0]  op_tag;
  logic [31:0] shift_out;

  function automatic logic [31:0] bit_rev(input logic [31:0] x);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      r[i] = x[31-i];
    end
    return r;
  endfunction

  // Left shifts reuse the right-shift stages by reversing bits on the way in and out.
  function automatic logic [31:0] barrel(input logic [31:0] d, input logic [4:0] sa,
                                         input logic right, input logic arith);
    logic        fill;
    logic [31:0] s0, s1, s2, s3, s4, s5;
    fill = right & arith & d[31];
    s0   = right ? d : bit_rev(d);
    s1   = sa[0] ? {fill, s0[31:1]} : s0;
    s2   = sa[1] ? {{2{fill}}, s1[31:2]} : s1;
    s3   = sa[2] ? {{4{fill}}, s2[31:4]} : s2;
    s4   = sa[3] ? {{8{fill}}, s3[31:8]} : s3;
    s5   = sa[4] ? {{16{fill}}, s4[31:16]} : s4;
    return right ? s5 : bit_rev(s5);
  endfunction

  always_comb begin
    slot_free = !res_valid_q || res_ready;
    gnt1 = req1_valid &&
           (!req0_valid || (!PRIO_FIXED && (last_grant_q == GRANT_P0)));
    gnt0 = req0_valid && !gnt1;

    req0_ready = clrn && slot_free && gnt0;
    req1_ready = clrn && slot_free && gnt1;
    accept     = req0_ready || req1_ready;

    op_d     = gnt1 ? req1_d     : req0_d;
    op_sa    = gnt1 ? req1_sa    : req0_sa;
    op_right = gnt1 ? req1_right : req0_right;
    op_arith = gnt1 ? req1_arith : req0_arith;
    op_tag   = gnt1 ? req1_tag   : req0_tag;
    shift_out = barrel(op_d, op_sa, op_right, op_arith);
  end

  always_comb begin
    last_grant_d = last_grant_q;
    res_valid_d  = res_valid_q;
    res_sh_d     = res_sh_q;
    res_src_d    = res_src_q;
    res_tag_d    = res_tag_q;
    done_cnt_d   = done_cnt_q;

    if (res_valid_q && res_ready) begin
      done_cnt_d  = done_cnt_q + 16'd1;
      res_valid_d = 1'b0;
    end

    if (accept) begin
      res_valid_d  = 1'b1;
      res_sh_d     = shift_out;
      res_src_d    = gnt1;
      res_tag_d    = op_tag;
      last_grant_d = gnt1 ? GRANT_P1 : GRANT_P0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      last_grant_q <= GRANT_P1;
      res_valid_q  <= 1'b0;
      res_sh_q     <= '0;
      res_src_q    <= 1'b0;
      res_tag_q    <= '0;
      done_cnt_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      res_valid_q  <= res_valid_d;
      res_sh_q     <= res_sh_d;
      res_src_q    <= res_src_d;
      res_tag_q    <= res_tag_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sh    = res_sh_q;
  assign res_src   = res_src_q;
  assign res_tag   = res_tag_q;
  assign busy      = res_valid_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: a round-robin and a fixed-priority instance checked
// against a cycle-level reference model of the arbitration and shift rules.
module tb_shift_arbiter;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic [4:0]  sa;
    logic        right;
    logic        arith;
    logic [3:0]  tag;
  } req_t;

  logic        clk = 1'b0;
  logic        clrn;
  req_t        rq   [2][2];
  logic        rr   [2];
  logic        rdy  [2][2];
  logic        rv   [2];
  logic [31:0] rsh  [2];
  logic        rsrc [2];
  logic [3:0]  rtag [2];
  logic        bsy  [2];
  logic [15:0] cnt  [2];

  int n_checks = 0;
  int n_err    = 0;

  // reference model state, per instance (0 = round-robin, 1 = fixed priority)
  bit          m_vld  [2];
  logic [31:0] m_sh   [2];
  bit          m_src  [2];
  logic [3:0]  m_tag  [2];
  logic [15:0] m_cnt  [2];
  int          m_last [2];
  bit          acc    [2][2];
  bit          prio   [2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  shift_arbiter #(.PRIO_FIXED(1'b0)) u_rr (
    .clk(clk), .clrn(clrn),
    .req0_valid(rq[0][0].v), .req0_ready(rdy[0][0]), .req0_d(rq[0][0].d),
    .req0_sa(rq[0][0].sa), .req0_right(rq[0][0].right), .req0_arith(rq[0][0].arith),
    .req0_tag(rq[0][0].tag),
    .req1_valid(rq[0][1].v), .req1_ready(rdy[0][1]), .req1_d(rq[0][1].d),
    .req1_sa(rq[0][1].sa), .req1_right(rq[0][1].right), .req1_arith(rq[0][1].arith),
    .req1_tag(rq[0][1].tag),
    .res_valid(rv[0]), .res_ready(rr[0]), .res_sh(rsh[0]), .res_src(rsrc[0]),
    .res_tag(rtag[0]), .busy(bsy[0]), .done_cnt(cnt[0])
  );

  shift_arbiter #(.PRIO_FIXED(1'b1)) u_fx (
    .clk(clk), .clrn(clrn),
    .req0_valid(rq[1][0].v), .req0_ready(rdy[1][0]), .req0_d(rq[1][0].d),
    .req0_sa(rq[1][0].sa), .req0_right(rq[1][0].right), .req0_arith(rq[1][0].arith),
    .req0_tag(rq[1][0].tag),
    .req1_valid(rq[1][1].v), .req1_ready(rdy[1][1]), .req1_d(rq[1][1].d),
    .req1_sa(rq[1][1].sa), .req1_right(rq[1][1].right), .req1_arith(rq[1][1].arith),
    .req1_tag(rq[1][1].tag),
    .res_valid(rv[1]), .res_ready(rr[1]), .res_sh(rsh[1]), .res_src(rsrc[1]),
    .res_tag(rtag[1]), .busy(bsy[1]), .done_cnt(cnt[1])
  );

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sa,
                                            input bit right, input bit arith);
    longint unsigned w = 64'(d);
    longint unsigned p = 64'd1 << sa;
    if (!right) return 32'((w * p) & 64'hFFFF_FFFF);
    if (arith && d[31]) return ~32'((~w & 64'hFFFF_FFFF) / p);
    return 32'(w / p);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input int p, input bit v, input logic [31:0] d,
                         input logic [4:0] sa, input bit right, input bit arith,
                         input logic [3:0] tag);
    rq[k][p].v = v; rq[k][p].d = d; rq[k][p].sa = sa;
    rq[k][p].right = right; rq[k][p].arith = arith; rq[k][p].tag = tag;
  endtask

  task automatic rand_req(input int k, input int p);
    int r = $urandom_range(0, 9);
    rq[k][p].v     = 1'b1;
    rq[k][p].d     = $urandom;
    rq[k][p].sa    = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom_range(0, 31));
    rq[k][p].right = 1'($urandom_range(0, 1));
    rq[k][p].arith = 1'($urandom_range(0, 1));
    rq[k][p].tag   = 4'($urandom_range(0, 15));
  endtask

  // Called just after a negedge with inputs driven; returns at the next negedge.
  task automatic step();
    bit exp_r [2][2];
    #1;
    for (int k = 0; k < 2; k++) begin
      bit free = !m_vld[k] || rr[k];
      int win = -1;
      if (rq[k][0].v && rq[k][1].v) win = prio[k] ? 0 : 1 - m_last[k];
      else if (rq[k][0].v) win = 0;
      else if (rq[k][1].v) win = 1;
      for (int p = 0; p < 2; p++) begin
        exp_r[k][p] = clrn && free && (win == p);
        chk($sformatf("ready%0d_dut%0d", p, k), 32'(rdy[k][p]), 32'(exp_r[k][p]));
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      acc[k][0] = 1'b0;
      acc[k][1] = 1'b0;
      if (!clrn) begin
        m_vld[k] = 1'b0; m_sh[k] = '0; m_src[k] = 1'b0; m_tag[k] = '0;
        m_cnt[k] = '0; m_last[k] = 1;
      end else begin
        if (m_vld[k] && rr[k]) begin
          m_cnt[k] = m_cnt[k] + 16'd1;
          m_vld[k] = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
          if (exp_r[k][p]) begin
            m_sh[k]   = ref_shift(rq[k][p].d, int'(rq[k][p].sa), rq[k][p].right, rq[k][p].arith);
            m_src[k]  = (p == 1);
            m_tag[k]  = rq[k][p].tag;
            m_vld[k]  = 1'b1;
            m_last[k] = p;
            acc[k][p] = 1'b1;
          end
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("res_valid_dut%0d", k), 32'(rv[k]), 32'(m_vld[k]));
      chk($sformatf("busy_dut%0d", k), 32'(bsy[k]), 32'(m_vld[k]));
      chk($sformatf("res_sh_dut%0d", k), rsh[k], m_sh[k]);
      chk($sformatf("res_src_dut%0d", k), 32'(rsrc[k]), 32'(m_src[k]));
      chk($sformatf("res_tag_dut%0d", k), 32'(rtag[k]), 32'(m_tag[k]));
      chk($sformatf("done_cnt_dut%0d", k), 32'(cnt[k]), 32'(m_cnt[k]));
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] vec_exp [4] = '{32'hF800_0000, 32'h0800_0000, 32'h0000_0010, 32'h8000_0001};
    bit          vec_rt  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit          vec_ar  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [4:0]  vec_sa  [4] = '{5'd4, 5'd4, 5'd4, 5'd0};
    logic [31:0] h_sh;
    logic [3:0]  h_tag;
    logic [15:0] h_cnt;

    for (int k = 0; k < 2; k++) begin
      m_vld[k] = 1'b0; m_sh[k] = '0; m_src[k] = 1'b0; m_tag[k] = '0;
      m_cnt[k] = '0; m_last[k] = 1; rr[k] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        acc[k][p] = 1'b0;
        set_req(k, p, 1'b1, 32'h1234_5678 + p, 5'd3, 1'b0, 1'b0, 4'(p + 1));
      end
    end
    clrn = 1'b0;
    @(negedge clk);

    // reset held two cycles with both ports requesting
    step();
    step();
    chk("reset_res_valid", 32'(rv[0]), 32'd0);
    chk("reset_res_sh", rsh[0], 32'd0);
    chk("reset_done_cnt", 32'(cnt[0]), 32'd0);

    clrn = 1'b1;
    step();
    chk("first_grant_port0", 32'(rsrc[0]), 32'd0);

    // single operations on port 0 of the round-robin instance
    rq[0][1].v = 1'b0;
    rq[1][0].v = 1'b0;
    rq[1][1].v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 0, 1'b1, 32'h8000_0001, vec_sa[i], vec_rt[i], vec_ar[i], 4'(9 + i));
      step();
      chk($sformatf("single_sh_%0d", i), rsh[0], vec_exp[i]);
      chk($sformatf("single_src_%0d", i), 32'(rsrc[0]), 32'd0);
      chk($sformatf("single_tag_%0d", i), 32'(rtag[0]), 32'(9 + i));
    end

    // round-robin on instance 0 and fixed priority on instance 1, from reset
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) rand_req(k, p);
    clrn = 1'b0;
    step();
    clrn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i < 4) chk($sformatf("rr_src_%0d", i), 32'(rsrc[0]), 32'(i % 2));
      chk($sformatf("fixed_src_%0d", i), 32'(rsrc[1]), 32'd0);
      chk($sformatf("fixed_ready1_%0d", i), 32'(rdy[1][1]), 32'd0);
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++) if (acc[k][p]) rand_req(k, p);
    end
    chk("rr_done_cnt_4", 32'(cnt[0]), 32'd4);

    // backpressure: result pending, consumer stalls three cycles
    rr[0] = 1'b0;
    h_sh  = m_sh[0];
    h_tag = m_tag[0];
    h_cnt = m_cnt[0];
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_sh_%0d", i), rsh[0], h_sh);
      chk($sformatf("stall_tag_%0d", i), 32'(rtag[0]), 32'(h_tag));
      chk($sformatf("stall_cnt_%0d", i), 32'(cnt[0]), 32'(h_cnt));
    end
    rr[0] = 1'b1;
    step();
    chk("stall_release_cnt", 32'(cnt[0]), 32'(h_cnt + 16'd1));
    chk("stall_release_refill", 32'(rv[0]), 32'd1);

    // reset while a result is held under backpressure
    rr[0] = 1'b0;
    for (int p = 0; p < 2; p++) if (acc[0][p]) rand_req(0, p);
    step();
    clrn = 1'b0;
    step();
    chk("midreset_res_valid", 32'(rv[0]), 32'd0);
    chk("midreset_done_cnt", 32'(cnt[0]), 32'd0);
    clrn  = 1'b1;
    rr[0] = 1'b1;
    rq[0][0].v = 1'b1;
    rq[0][1].v = 1'b1;
    step();
    chk("midreset_first_port0", 32'(rsrc[0]), 32'd0);

    // randomized traffic with occasional resets and backpressure
    for (int i = 0; i < 400; i++) begin
      clrn = ($urandom_range(0, 63) != 0);
      for (int k = 0; k < 2; k++) begin
        rr[k] = ($urandom_range(0, 3) != 0);
        for (int p = 0; p < 2; p++) begin
          if (acc[k][p] || !rq[k][p].v) begin
            if ($urandom_range(0, 2) != 0) rand_req(k, p);
            else rq[k][p].v = 1'b0;
          end
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
